mgmt_mprj_wb_arbiter: RTL

- Shares the exported user-project Wishbone port (mprj_*) between two management-side masters.
  - Master 0 is the CPU data bus.
  - Master 1 is the debug/DMA master.
- Arbitration is round-robin. A grant is held for the whole bus cycle.
- A bus watchdog terminates hung user-project transactions with an error response.
- Sits inside mgmt_core between the SoC interconnect and the mprj_* wrapper pins. It also drives mprj_wb_iena.

---
 rtl/mgmt_mprj_wb_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mgmt_mprj_wb_arbiter.sv
// Two-master Wishbone arbiter for the exported user-project port.
// Master 0 is the CPU data bus and master 1 is the debug/DMA master.
// Arbitration is round-robin, and a grant is held for the whole bus cycle
// (cyc high). A watchdog ends stalled slave transfers with an error response.
module mgmt_mprj_wb_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        core_clk,
  input  logic        core_rstn,
  // master 0 (CPU data bus)
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,
  // master 1 (debug / DMA)
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,
  // user-project slave port
  output logic        mprj_cyc_o,
  output logic        mprj_stb_o,
  output logic        mprj_we_o,
  output logic [3:0]  mprj_sel_o,
  output logic [31:0] mprj_adr_o,
  output logic [31:0] mprj_dat_o,
  input  logic        mprj_ack_i,
  input  logic [31:0] mprj_dat_i,
  output logic        mprj_wb_iena,
  // status
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_BUSY      = 2'd1;
  localparam logic [1:0] S_ERR       = 2'd2;
  localparam logic [1:0] S_WAIT_DROP = 2'd3;

  // The last stalled count before expiry. The counter must be wide enough
  // to hold this value.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state, state_nxt;
  logic [1:0]       grant, grant_nxt;
  logic             rr_last, rr_last_nxt;   // 1: master 1 won last
  logic [CNT_W-1:0] wd_cnt, wd_cnt_nxt;

  logic req0, req1;
  logic g_cyc, g_stb, g_we;
  logic [3:0]  g_sel;
  logic [31:0] g_adr, g_dat;
  logic busy, err, stall, expire;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  // Select the signals of the granted master. The grant is one-hot, and
  // these signals are only used while a grant is held.
  always_comb begin
    g_cyc = m0_cyc_i;
    g_stb = m0_stb_i;
    g_we  = m0_we_i;
    g_sel = m0_sel_i;
    g_adr = m0_adr_i;
    g_dat = m0_dat_i;
    if (grant[1]) begin
      g_cyc = m1_cyc_i;
      g_stb = m1_stb_i;
      g_we  = m1_we_i;
      g_sel = m1_sel_i;
      g_adr = m1_adr_i;
      g_dat = m1_dat_i;
    end
  end

  assign busy   = (state == S_BUSY);
  assign err    = (state == S_ERR);
  assign stall  = busy & g_cyc & g_stb & ~mprj_ack_i;
  assign expire = stall & (wd_cnt == TMO_LAST);

  // Next-state logic: arbitration, burst hold, watchdog and error handshake.
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    rr_last_nxt = rr_last;
    wd_cnt_nxt  = wd_cnt;
    case (state)
      S_IDLE: begin
        wd_cnt_nxt = '0;
        // On a tie the master that did not win last time gets the grant.
        if (req0 && (!req1 || rr_last)) begin
          grant_nxt   = 2'b01;
          rr_last_nxt = 1'b0;
          state_nxt   = S_BUSY;
        end else if (req1) begin
          grant_nxt   = 2'b10;
          rr_last_nxt = 1'b1;
          state_nxt   = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!g_cyc) begin
          state_nxt = S_IDLE;
          grant_nxt = 2'b00;
        end else if (mprj_ack_i) begin
          wd_cnt_nxt = '0;               // an ack on the expiry cycle wins
        end else if (expire) begin
          state_nxt = S_ERR;
        end else if (g_stb) begin
          wd_cnt_nxt = wd_cnt + CNT_W'(1);
        end
      end
      S_ERR: begin
        state_nxt = S_WAIT_DROP;
      end
      S_WAIT_DROP: begin
        if (!g_cyc) begin
          state_nxt = S_IDLE;
          grant_nxt = 2'b00;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        grant_nxt = 2'b00;
      end
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      state   <= S_IDLE;
      grant   <= 2'b00;
      rr_last <= 1'b1;
      wd_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      rr_last <= rr_last_nxt;
      wd_cnt  <= wd_cnt_nxt;
    end
  end

  // Route the granted master to the slave only while BUSY. In every other
  // state the slave port is held at zero.
  always_comb begin
    mprj_cyc_o = 1'b0;
    mprj_stb_o = 1'b0;
    mprj_we_o  = 1'b0;
    mprj_sel_o = 4'h0;
    mprj_adr_o = 32'h0;
    mprj_dat_o = 32'h0;
    if (busy) begin
      mprj_cyc_o = g_cyc;
      mprj_stb_o = g_stb;
      mprj_we_o  = g_we;
      mprj_sel_o = g_sel;
      mprj_adr_o = g_adr;
      mprj_dat_o = g_dat;
    end
  end

  // Return path: only the granted master sees ack/data. The error cycle
  // returns all-ones data.
  always_comb begin
    m0_ack_o = busy & grant[0] & mprj_ack_i;
    m1_ack_o = busy & grant[1] & mprj_ack_i;
    m0_err_o = err & grant[0];
    m1_err_o = err & grant[1];
    m0_dat_o = 32'h0;
    m1_dat_o = 32'h0;
    if (busy && grant[0]) m0_dat_o = mprj_dat_i;
    if (busy && grant[1]) m1_dat_o = mprj_dat_i;
    if (err && grant[0])  m0_dat_o = 32'hFFFF_FFFF;
    if (err && grant[1])  m1_dat_o = 32'hFFFF_FFFF;
  end

  assign grant_o      = grant;
  assign mprj_wb_iena = |grant;
  assign timeout_o    = err;

endmodule
